// File: rtl/interval_stopwatch.sv
// Interval stopwatch: counts prescaled tick pulses between start and stop
// into a saturating 4-digit BCD value for direct display.
module interval_stopwatch #(
  parameter int unsigned TICKS_PER_COUNT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] bcd_count,
  output logic        running,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_COUNT - 1);
  localparam logic [15:0] BCD_MAX = 16'h9999;

  state_t      r_state;
  state_t      w_state;
  logic [15:0] r_count;
  logic [15:0] w_count;
  logic [7:0]  r_pre;
  logic [7:0]  w_pre;
  logic        r_done;
  logic        w_done;
  logic        r_ovf;
  logic        w_ovf;
  logic        r_running;
  logic        w_wrap;

  // Ripple-carry BCD increment; each digit wraps 9 -> 0 and carries up
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_wrap = (r_pre == PRE_MAX);

  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_pre   = r_pre;
    w_ovf   = r_ovf;
    w_done  = 1'b0;
    if (clear) begin
      w_state = S_IDLE;
      w_count = '0;
      w_pre   = '0;
      w_ovf   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state = S_RUN;
            w_count = '0;
            w_pre   = '0;
            w_ovf   = 1'b0;
          end
        end
        S_RUN: begin
          if (start && !stop) begin
            w_count = '0;
            w_pre   = '0;
          end else begin
            // A tick alongside stop still counts with the old prescale
            if (tick) begin
              if (w_wrap) begin
                w_pre = '0;
                if (r_count == BCD_MAX) begin
                  w_ovf   = 1'b1;
                  w_state = S_HOLD;
                  w_done  = 1'b1;
                end else begin
                  w_count = bcd_inc(r_count);
                end
              end else begin
                w_pre = r_pre + 8'd1;
              end
            end
            if (stop) begin
              w_state = S_HOLD;
              w_done  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (start) begin
            w_state = S_RUN;
            w_count = '0;
            w_pre   = '0;
            w_ovf   = 1'b0;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_pre     <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_pre     <= w_pre;
      r_done    <= w_done;
      r_ovf     <= w_ovf;
      r_running <= (w_state == S_RUN);
    end
  end

  assign bcd_count = r_count;
  assign running   = r_running;
  assign done      = r_done;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_interval_stopwatch.sv
// Bench for interval_stopwatch: two instances (prescale 1 and 4) checked
// against an integer-count reference model.
module tb_interval_stopwatch;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] bcd1;
  logic [15:0] bcd4;
  logic        run1;
  logic        run4;
  logic        done1;
  logic        done4;
  logic        ovf1;
  logic        ovf4;

  int total = 0;
  int bad   = 0;
  int dn1   = 0;
  int dn4   = 0;
  int digit_bad = 0;

  // model: st 0=idle 1=run 2=hold, n = plain integer count
  int m_st[2];
  int m_n[2];
  int m_pre[2];
  int m_ovf[2];
  int m_done[2];

  interval_stopwatch #(.TICKS_PER_COUNT(1)) u_dut1 (
    .clock(clock), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .clear(clear), .bcd_count(bcd1), .running(run1),
    .done(done1), .overflow(ovf1)
  );

  interval_stopwatch #(.TICKS_PER_COUNT(4)) u_dut4 (
    .clock(clock), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .clear(clear), .bcd_count(bcd4), .running(run4),
    .done(done4), .overflow(ovf4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int n);
    return 16'(((n / 1000) % 10) << 12 | ((n / 100) % 10) << 8 |
                ((n / 10) % 10) << 4 | (n % 10));
  endfunction

  function automatic int has_bad_digit(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++)
      if (((v >> (i * 4)) & 16'hF) > 16'd9) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_n[k] = 0; m_pre[k] = 0;
      m_ovf[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_tick(input int k);
    int tpc;
    tpc = (k == 0) ? 1 : 4;
    m_pre[k]++;
    if (m_pre[k] == tpc) begin
      m_pre[k] = 0;
      if (m_n[k] == 9999) begin
        m_ovf[k] = 1; m_st[k] = 2; m_done[k] = 1;
      end else begin
        m_n[k]++;
      end
    end
  endtask

  task automatic model_upd(input logic t, s, p, c);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (c) begin
        m_st[k] = 0; m_n[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
      end else if (m_st[k] == 0) begin
        if (s) begin
          m_st[k] = 1; m_n[k] = 0; m_pre[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (p) begin
          if (t) model_tick(k);
          m_st[k] = 2; m_done[k] = 1;
        end else if (s) begin
          m_n[k] = 0; m_pre[k] = 0;
        end else if (t) begin
          model_tick(k);
        end
      end else begin
        if (s) begin
          m_st[k] = 1; m_n[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic t, s, p, c);
    tick = t; start = s; stop = p; clear = c;
    @(posedge clock);
    #1;
    model_upd(t, s, p, c);
    tick = 0; start = 0; stop = 0; clear = 0;
    if (done1) dn1++;
    if (done4) dn4++;
    if (has_bad_digit(bcd1) != 0 || has_bad_digit(bcd4) != 0) digit_bad++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if (bcd1 !== 16'h0 || run1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL reset1 got=%h/%b/%b/%b exp=0000/0/0/0", bcd1, run1, done1, ovf1);
    end
    total++;
    if (bcd4 !== 16'h0 || run4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4 got=%h/%b/%b/%b exp=0000/0/0/0", bcd4, run4, done4, ovf4);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(2);
  endtask

  task automatic test_basic();
    dn1 = 0;
    step(0, 1, 0, 0);
    total++;
    if (run1 !== 1'b1) begin
      bad++; $display("FAIL basic_run got=%b exp=1", run1);
    end
    for (int i = 0; i < 37; i++) begin
      step(1, 0, 0, 0);
      idle(4);
    end
    step(0, 0, 1, 0);
    idle(3);
    total++;
    if (bcd1 !== 16'h0037) begin
      bad++; $display("FAIL basic_cnt got=%h exp=0037", bcd1);
    end
    total++;
    if (bcd4 !== to_bcd(m_n[1])) begin
      bad++; $display("FAIL basic_cnt4 got=%h exp=%h", bcd4, to_bcd(m_n[1]));
    end
    total++;
    if (dn1 !== 1 || run1 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++; $display("FAIL basic_flags got=%0d/%b/%b exp=1/0/0", dn1, run1, ovf1);
    end
  endtask

  task automatic test_prescale();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    total++;
    if (bcd4 !== 16'h0002 || bcd1 !== 16'h0010) begin
      bad++; $display("FAIL presc_10 got=%h/%h exp=0002/0010", bcd4, bcd1);
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    total++;
    if (bcd4 !== 16'h0001 || run4 !== 1'b1) begin
      bad++; $display("FAIL presc_restart got=%h/%b exp=0001/1", bcd4, run4);
    end
  endtask

  task automatic test_carry();
    logic [15:0] exp;
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    digit_bad = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1, 0, 0, 0);
      exp = 16'hFFFF;
      case (i)
        9:    exp = 16'h0009;
        10:   exp = 16'h0010;
        99:   exp = 16'h0099;
        100:  exp = 16'h0100;
        999:  exp = 16'h0999;
        1000: exp = 16'h1000;
        default: exp = 16'hFFFF;
      endcase
      if (exp != 16'hFFFF) begin
        total++;
        if (bcd1 !== exp) begin
          bad++; $display("FAIL carry_%0d got=%h exp=%h", i, bcd1, exp);
        end
      end
    end
    total++;
    if (bcd4 !== to_bcd(m_n[1])) begin
      bad++; $display("FAIL carry4 got=%h exp=%h", bcd4, to_bcd(m_n[1]));
    end
    total++;
    if (digit_bad !== 0) begin
      bad++; $display("FAIL digit_range got=%0d exp=0", digit_bad);
    end
  endtask

  task automatic test_saturate();
    int sat_at;
    int d1_at_sat;
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    dn1 = 0;
    sat_at = 0;
    for (int i = 1; i <= 10005; i++) begin
      step(1, 0, 0, 0);
      if (done1 && sat_at == 0) sat_at = i;
    end
    d1_at_sat = dn1;
    total++;
    if (bcd1 !== 16'h9999 || ovf1 !== 1'b1 || run1 !== 1'b0) begin
      bad++; $display("FAIL sat_state got=%h/%b/%b exp=9999/1/0", bcd1, ovf1, run1);
    end
    total++;
    if (sat_at !== 10000 || d1_at_sat !== 1) begin
      bad++; $display("FAIL sat_done got=%0d/%0d exp=10000/1", sat_at, d1_at_sat);
    end
    total++;
    if (bcd4 !== to_bcd(m_n[1]) || ovf4 !== 1'(m_ovf[1])) begin
      bad++; $display("FAIL sat4 got=%h/%b exp=%h/%0d", bcd4, ovf4, to_bcd(m_n[1]), m_ovf[1]);
    end
    step(0, 1, 0, 0);
    total++;
    if (bcd1 !== 16'h0 || ovf1 !== 1'b0 || run1 !== 1'b1) begin
      bad++; $display("FAIL sat_restart got=%h/%b/%b exp=0000/0/1", bcd1, ovf1, run1);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    dn1 = 0;
    step(1, 0, 1, 0);
    idle(2);
    total++;
    if (bcd1 !== 16'h0006 || dn1 !== 1 || run1 !== 1'b0) begin
      bad++; $display("FAIL stop_tick got=%h/%0d/%b exp=0006/1/0", bcd1, dn1, run1);
    end
    step(1, 1, 0, 0);
    total++;
    if (bcd1 !== 16'h0000 || run1 !== 1'b1) begin
      bad++; $display("FAIL start_tick_hold got=%h/%b exp=0000/1", bcd1, run1);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    dn1 = 0;
    step(0, 1, 1, 0);
    total++;
    if (bcd1 !== 16'h0003 || run1 !== 1'b0 || dn1 !== 1) begin
      bad++; $display("FAIL start_stop_run got=%h/%b/%0d exp=0003/0/1", bcd1, run1, dn1);
    end
    step(0, 0, 0, 1);
    dn1 = 0;
    step(0, 0, 1, 0);
    idle(2);
    total++;
    if (dn1 !== 0 || run1 !== 1'b0) begin
      bad++; $display("FAIL stop_idle got=%0d/%b exp=0/0", dn1, run1);
    end
  endtask

  task automatic test_reset_clear_mid();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 42; i++) step(1, 0, 0, 0);
    total++;
    if (bcd1 !== 16'h0042) begin
      bad++; $display("FAIL pre_reset got=%h exp=0042", bcd1);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bcd1 !== 16'h0 || run1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%b/%b/%b exp=0000/0/0/0", bcd1, run1, done1, ovf1);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    dn1 = 0;
    idle(2);
    total++;
    if (dn1 !== 0 || run1 !== 1'b0 || bcd1 !== 16'h0) begin
      bad++; $display("FAIL post_reset got=%0d/%b/%h exp=0/0/0000", dn1, run1, bcd1);
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 42; i++) step(1, 0, 0, 0);
    dn1 = 0;
    step(1, 0, 1, 1);
    idle(2);
    total++;
    if (bcd1 !== 16'h0 || run1 !== 1'b0 || dn1 !== 0 || ovf1 !== 1'b0) begin
      bad++; $display("FAIL clear_mid got=%h/%b/%0d/%b exp=0000/0/0/0", bcd1, run1, dn1, ovf1);
    end
  endtask

  task automatic test_random();
    logic t, s, p, c;
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 199) == 0);
      step(t, s, p, c);
      total++;
      if (bcd1 !== to_bcd(m_n[0]) || run1 !== (m_st[0] == 1) ||
          done1 !== 1'(m_done[0]) || ovf1 !== 1'(m_ovf[0])) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rand1 cyc=%0d got=%h/%b/%b/%b exp=%h/%0d/%0d/%0d", i,
                   bcd1, run1, done1, ovf1, to_bcd(m_n[0]), m_st[0] == 1,
                   m_done[0], m_ovf[0]);
      end
      total++;
      if (bcd4 !== to_bcd(m_n[1]) || run4 !== (m_st[1] == 1) ||
          done4 !== 1'(m_done[1]) || ovf4 !== 1'(m_ovf[1])) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rand4 cyc=%0d got=%h/%b/%b/%b exp=%h/%0d/%0d/%0d", i,
                   bcd4, run4, done4, ovf4, to_bcd(m_n[1]), m_st[1] == 1,
                   m_done[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_prescale();
    test_carry();
    test_saturate();
    test_simultaneous();
    test_reset_clear_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
